lcd_hd44780_driver: RTL

//  Responder end of the lcd16x2 host handshake (data_i/ops_i/enb_i/rst_i -> rdy_o).

---
 rtl/lcd_hd44780_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit LCD driver: power-on init, then one instruction/char per handshake.
// Ports: clk_i, rst_ni, host data_i/ops_i/enb_i/rst_i -> rdy_o; LCD lcd_rs_o/lcd_e_o/lcd_data_o.
module lcd_hd44780_driver #(
  parameter int T_PWR_CYC   = 2000000,
  parameter int T_INIT1_CYC = 500000,
  parameter int T_INIT2_CYC = 15000,
  parameter int T_AS_CYC    = 5,
  parameter int T_E_CYC     = 30,
  parameter int T_H_CYC     = 5,
  parameter int T_EXEC_CYC  = 5000,
  parameter int T_CLEAR_CYC = 200000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic [1:0] ops_i,
  input  logic       enb_i,
  input  logic       rst_i,
  output logic       rdy_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_data_o
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXW = max2(max2(max2(T_PWR_CYC, T_INIT1_CYC),
    max2(T_INIT2_CYC, T_AS_CYC)), max2(max2(T_E_CYC, T_H_CYC),
    max2(T_EXEC_CYC, T_CLEAR_CYC)));
  localparam int CW = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] PWR_L   = CW'(T_PWR_CYC - 1);
  localparam logic [CW-1:0] INIT1_L = CW'(T_INIT1_CYC - 1);
  localparam logic [CW-1:0] INIT2_L = CW'(T_INIT2_CYC - 1);
  localparam logic [CW-1:0] AS_L    = CW'(T_AS_CYC - 1);
  localparam logic [CW-1:0] E_L     = CW'(T_E_CYC - 1);
  localparam logic [CW-1:0] H_L     = CW'(T_H_CYC - 1);
  localparam logic [CW-1:0] EXEC_L  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] CLEAR_L = CW'(T_CLEAR_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, EPULSE, HOLD, EXEC_WAIT, IDLE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   lim, lim_n;
  logic [2:0]      idx, idx_n;
  logic            in_init, in_init_n;
  logic            rdy_n, rs_n, e_n;
  logic [7:0]      db_n;

  function automatic logic [7:0] rom_db(logic [2:0] i);
    unique case (i)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h08;
      3'd5:             return 8'h01;
      3'd6:             return 8'h06;
      default:          return 8'h0C;
    endcase
  endfunction

  function automatic logic [CW-1:0] rom_lim(logic [2:0] i);
    unique case (i)
      3'd0:    return INIT1_L;
      3'd1:    return INIT2_L;
      3'd5:    return CLEAR_L;
      default: return EXEC_L;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    lim_n     = lim;
    idx_n     = idx;
    in_init_n = in_init;
    rdy_n     = rdy_o;
    rs_n      = lcd_rs_o;
    e_n       = lcd_e_o;
    db_n      = lcd_data_o;
    if (rst_i) begin
      state_n   = PWR_WAIT;
      cnt_n     = '0;
      idx_n     = '0;
      in_init_n = 1'b1;
      rdy_n     = 1'b0;
      rs_n      = 1'b0;
      e_n       = 1'b0;
      db_n      = '0;
    end else begin
      unique case (state)
        PWR_WAIT: begin
          in_init_n = 1'b1;
          if (cnt == PWR_L) begin
            state_n = INIT_LOAD;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end
        INIT_LOAD: begin
          db_n    = rom_db(idx);
          lim_n   = rom_lim(idx);
          rs_n    = 1'b0;
          state_n = SETUP;
          cnt_n   = '0;
        end
        SETUP: if (cnt == AS_L) begin
          state_n = EPULSE;
          e_n     = 1'b1;
          cnt_n   = '0;
        end
        EPULSE: if (cnt == E_L) begin
          state_n = HOLD;
          e_n     = 1'b0;
          cnt_n   = '0;
        end
        HOLD: if (cnt == H_L) begin
          state_n = EXEC_WAIT;
          cnt_n   = '0;
        end
        EXEC_WAIT: if (cnt == lim) begin
          cnt_n = '0;
          if (in_init && idx != 3'd7) begin
            idx_n   = idx + 3'd1;
            state_n = INIT_LOAD;
          end else begin
            in_init_n = 1'b0;
            state_n   = IDLE;
            rdy_n     = 1'b1;
          end
        end
        default: begin
          cnt_n = '0;
          // reserved ops codes (bit 1 set) are silently dropped
          if (enb_i && !ops_i[1]) begin
            db_n    = data_i;
            rs_n    = ops_i[0];
            rdy_n   = 1'b0;
            state_n = SETUP;
            // clear/home need the long execution wait
            lim_n   = (!ops_i[0] && data_i inside {8'h01, 8'h02, 8'h03})
                      ? CLEAR_L : EXEC_L;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      lim        <= '0;
      idx        <= '0;
      in_init    <= 1'b1;
      rdy_o      <= 1'b0;
      lcd_rs_o   <= 1'b0;
      lcd_e_o    <= 1'b0;
      lcd_data_o <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lim        <= lim_n;
      idx        <= idx_n;
      in_init    <= in_init_n;
      rdy_o      <= rdy_n;
      lcd_rs_o   <= rs_n;
      lcd_e_o    <= e_n;
      lcd_data_o <= db_n;
    end
  end

endmodule
